// File: rtl/mmu_rev.sv
// Reverse address translator: finds the virtual address mapped to a physical
// address by scanning the mapping table one entry per cycle.
module mmu_rev #(
    parameter int ADDR_V_WIDTH = 26,
    parameter int ADDR_P_WIDTH = 30,
    parameter int DEPTH        = 1024,
    parameter int IDX_WIDTH    = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [IDX_WIDTH-1:0]    wr_idx,
    input  logic                    wr_valid,
    input  logic [ADDR_V_WIDTH-1:0] wr_va,
    input  logic [ADDR_P_WIDTH-1:0] wr_pa,
    input  logic                    req,
    input  logic [ADDR_P_WIDTH-1:0] req_pa,
    output logic                    busy,
    output logic                    done,
    output logic                    found,
    output logic [ADDR_V_WIDTH-1:0] va,
    output logic [IDX_WIDTH-1:0]    hit_idx
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [DEPTH-1:0]         r_valid;
    logic [ADDR_V_WIDTH-1:0]  r_va_mem [DEPTH];
    logic [ADDR_P_WIDTH-1:0]  r_pa_mem [DEPTH];
    logic [ADDR_P_WIDTH-1:0]  r_req_pa;
    logic [IDX_WIDTH-1:0]     r_idx;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_found;
    logic [ADDR_V_WIDTH-1:0]  r_va;
    logic [IDX_WIDTH-1:0]     r_hit_idx;
    logic                     w_match;
    logic                     w_last;

    // Asynchronous table read: a same-edge write is seen only by later compares.
    assign w_match = r_valid[r_idx] && (r_pa_mem[r_idx] == r_req_pa);
    assign w_last  = (r_idx == IDX_WIDTH'(DEPTH - 1));

    // Valid bits are the only table state cleared by reset.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[gi] <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_WIDTH'(gi))) begin
                    r_valid[gi] <= wr_valid;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_va_mem[wr_idx] <= wr_va;
            r_pa_mem[wr_idx] <= wr_pa;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (req) w_state_next = S_SCAN;
            S_SCAN:  if (w_match || w_last) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_req_pa  <= '0;
            r_idx     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_found   <= 1'b0;
            r_va      <= '0;
            r_hit_idx <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != S_IDLE);
            r_done  <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_req_pa <= req_pa;
                        r_idx    <= '0;
                    end
                end
                S_SCAN: begin
                    // First hit wins; va and hit_idx keep old values on a miss.
                    if (w_match) begin
                        r_found   <= 1'b1;
                        r_va      <= r_va_mem[r_idx];
                        r_hit_idx <= r_idx;
                    end else if (w_last) begin
                        r_found <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign found   = r_found;
    assign va      = r_va;
    assign hit_idx = r_hit_idx;

endmodule

// File: tb/tb_mmu_rev.sv
// Scoreboard bench for mmu_rev: a table model predicts each lookup result and
// its completion edge; a negedge monitor checks every done pulse.
module tb_mmu_rev;
    localparam int VW = 26;
    localparam int PW = 30;
    localparam int DEPTH = 1024;
    localparam int IW = 10;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic          wr_valid;
    logic [VW-1:0] wr_va;
    logic [PW-1:0] wr_pa;
    logic          req;
    logic [PW-1:0] req_pa;
    logic          busy, done, found;
    logic [VW-1:0] va;
    logic [IW-1:0] hit_idx;

    mmu_rev #(.ADDR_V_WIDTH(VW), .ADDR_P_WIDTH(PW), .DEPTH(DEPTH), .IDX_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_idx(wr_idx), .wr_valid(wr_valid),
        .wr_va(wr_va), .wr_pa(wr_pa), .req(req), .req_pa(req_pa), .busy(busy),
        .done(done), .found(found), .va(va), .hit_idx(hit_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          found;
        logic [VW-1:0] va;
        logic [IW-1:0] hit;
        int            off;
        int            req_edge;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   prev_done = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference table and the result registers it implies.
    bit            m_valid [DEPTH];
    logic [VW-1:0] m_va    [DEPTH];
    logic [PW-1:0] m_pa    [DEPTH];
    logic [VW-1:0] last_va;
    logic [IW-1:0] last_hit;
    logic [PW-1:0] pool [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done <= 1'b0;
        end else begin
            if (done) begin
                chk("done_single_cycle", {63'd0, prev_done}, 64'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("found", {63'd0, found}, {63'd0, mon_e.found});
                    chk("va", {38'd0, va}, {38'd0, mon_e.va});
                    chk("hit_idx", {54'd0, hit_idx}, {54'd0, mon_e.hit});
                    chk("done_edge", 64'(cyc - mon_e.req_edge), 64'(mon_e.off));
                    $display("lookup done: found=%0d va=%h hit_idx=%0d after %0d edges",
                             found, va, hit_idx, cyc - mon_e.req_edge);
                end
            end
            prev_done <= done;
        end
    end

    task automatic install(input int idx, input bit v, input logic [VW-1:0] a_va,
                           input logic [PW-1:0] a_pa);
        @(negedge clk);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_valid = v; wr_va = a_va; wr_pa = a_pa;
        @(negedge clk);
        wr_en = 1'b0;
        m_valid[idx] = v; m_va[idx] = a_va; m_pa[idx] = a_pa;
    endtask

    // Lookup with an optional write (and optional extra req) landing on edge t after the req edge.
    task automatic lookup(input logic [PW-1:0] pa, input bit mid_en, input int t, input int widx,
                          input bit wval, input logic [VW-1:0] wva, input logic [PW-1:0] wpa,
                          input bit rq_pulse);
        exp_t e;
        int k;
        bit v;
        logic [PW-1:0] p;
        logic [VW-1:0] a;
        k = -1;
        a = '0;
        for (int i = 0; i < DEPTH; i++) begin
            v = m_valid[i]; p = m_pa[i];
            if (mid_en && i == widx && t <= i) begin
                v = wval; p = wpa;
            end
            if (v && p == pa) begin
                k = i;
                a = (mid_en && i == widx && t <= i) ? wva : m_va[i];
                break;
            end
        end
        if (k >= 0) begin
            last_va = a; last_hit = IW'(k);
            e.found = 1'b1; e.off = k + 1;
        end else begin
            e.found = 1'b0; e.off = DEPTH;
        end
        e.va = last_va; e.hit = last_hit;
        @(negedge clk);
        req = 1'b1; req_pa = pa;
        @(negedge clk);
        req = 1'b0; req_pa = $urandom();
        e.req_edge = cyc;
        sb.push_back(e);
        if (mid_en || rq_pulse) begin
            for (int j = 1; j < t; j++) @(negedge clk);
            if (mid_en) begin
                wr_en = 1'b1; wr_idx = IW'(widx); wr_valid = wval; wr_va = wva; wr_pa = wpa;
            end
            if (rq_pulse && t <= e.off + 1) begin
                req = 1'b1; req_pa = pa;
            end
            @(negedge clk);
            wr_en = 1'b0; req = 1'b0;
            if (mid_en) begin
                m_valid[widx] = wval; m_va[widx] = wva; m_pa[widx] = wpa;
            end
        end
        for (int j = 0; j < DEPTH + 10 && busy; j++) @(negedge clk);
        if (busy) chk("busy_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int tt;
        rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_valid = 1'b0; wr_va = '0; wr_pa = '0;
        req = 1'b0; req_pa = '0;
        last_va = '0; last_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0; m_va[i] = '0; m_pa[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_found", {63'd0, found}, 64'd0);
        chk("rst_va", {38'd0, va}, 64'd0);
        chk("rst_hit_idx", {54'd0, hit_idx}, 64'd0);
        rst_n = 1'b1;

        lookup(30'h0000100, 0, 0, 0, 0, '0, '0, 0);
        install(5, 1, 26'h0123456, 30'h0ABCDEF);
        lookup(30'h0ABCDEF, 0, 0, 0, 0, '0, '0, 0);
        install(3, 1, 26'h0000AAA, 30'h0000040);
        install(7, 1, 26'h0000BBB, 30'h0000040);
        lookup(30'h0000040, 0, 0, 0, 0, '0, '0, 0);
        install(5, 0, 26'h0123456, 30'h0ABCDEF);
        lookup(30'h0ABCDEF, 0, 0, 0, 0, '0, '0, 0);
        lookup(30'h1234567, 1, 11, 900, 1, 26'h0000321, 30'h1234567, 1);
        // Write lands exactly on the edge that compares index 12: the old contents must win.
        lookup(30'h2222222, 1, 13, 12, 1, 26'h0000777, 30'h2222222, 0);

        // Abort a scan at index 50 with an asynchronous reset.
        @(negedge clk);
        req = 1'b1; req_pa = 30'h3333333;
        @(negedge clk);
        req = 1'b0;
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        last_va = '0; last_hit = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        lookup(30'h1234567, 0, 0, 0, 0, '0, '0, 0);

        for (int i = 0; i < 6; i++) pool[i] = PW'($urandom());
        for (int n = 0; n < 24; n++) begin
            for (int m = $urandom_range(3); m > 0; m--)
                install($urandom_range(DEPTH - 1), ($urandom_range(7) != 0),
                        VW'($urandom()), pool[$urandom_range(5)]);
            tt = $urandom_range(DEPTH, 1);
            lookup(($urandom_range(3) != 0) ? pool[$urandom_range(5)] : PW'($urandom()),
                   $urandom_range(1), tt, $urandom_range(DEPTH - 1), $urandom_range(1),
                   VW'($urandom()), pool[$urandom_range(5)], $urandom_range(1));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/mmu_rev.md
# mmu_rev

Reverse address translator for the memory hierarchy: given a physical address, it returns the virtual address mapped to it. It is used by the coherence and snoop paths, which see physical addresses but must index virtually-tagged structures. It owns its own mapping table, written through a simple install port. Lookups scan the table sequentially, one entry per cycle, under a request/done handshake, so area stays small at DEPTH = 1K.

## Interface
- ADDR_V_WIDTH, 26, virtual address width
- ADDR_P_WIDTH, 30, physical word address width (2-bit byte offset excluded)
- DEPTH, 1024, table entries; power of two, ≥ 2
- IDX_WIDTH, 10, log2(DEPTH)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- wr_en  in  1  install/invalidate strobe, sampled each edge
- wr_idx  in  IDX_WIDTH  entry to write
- wr_valid  in  1  1 = install mapping, 0 = invalidate entry
- wr_va  in  ADDR_V_WIDTH  virtual address to install
- wr_pa  in  ADDR_P_WIDTH  physical address to install
- req  in  1  lookup request, accepted only in IDLE
- req_pa  in  ADDR_P_WIDTH  physical address to translate, sampled with req
- busy  out  1  high in SCAN and DONE
- done  out  1  high for exactly one cycle when a result is valid
- found  out  1  1 = hit, 0 = miss; held until the next completion
- va  out  ADDR_V_WIDTH  translated virtual address; held; unchanged on miss
- hit_idx  out  IDX_WIDTH  matching entry index; held; unchanged on miss

## Operation
- Storage: per entry, valid bit, va, and pa. Reset clears all valid bits; va/pa contents are not reset.
- Write: when wr_en is high at an edge, entry wr_idx gets valid = wr_valid, va = wr_va, pa = wr_pa. Writes are legal in any state.
- FSM states: IDLE, SCAN, DONE.
  - IDLE: req=1 latches req_pa, sets scan index to 0, goes to SCAN. req=0 stays in IDLE.
  - SCAN: each cycle compares entry[idx]; match = valid && pa == latched pa.
    - Match: register va, hit_idx = idx, found = 1; go to DONE.
    - No match with idx == DEPTH-1: found = 0; go to DONE.
    - Otherwise idx++.
  - DONE: done = 1 for this one cycle, then unconditionally back to IDLE.
- Multiple matching entries: the lowest index wins, because the scan stops at the first hit.
- req while busy (SCAN or DONE) is ignored, not queued. The requester must re-present it after done.
- Same-edge write and compare to the same index: the compare sees the old contents (read before write).
- A write to an index the scan has not yet reached is visible when the scan reaches it. A write to an index already passed has no effect on the current lookup.
- Index counter: IDX_WIDTH bits, never wraps. The terminal compare at DEPTH-1 ends the scan.

## Timing
- Reset values (asynchronous, while rst_n = 0):
  - state = IDLE; busy = 0, done = 0, found = 0; va = 0, hit_idx = 0; all valid bits = 0.
- Reset asserted mid-scan aborts the lookup immediately; no done is produced.
- All outputs are registered.
- Edge E0 samples req. busy is high from after E0 until after the edge that leaves DONE.
- Hit at index k: done is high in the cycle after edge E(k+1). Request-to-done latency is k+2 cycles.
- Miss: done is high after edge E(DEPTH). Latency is DEPTH+1 cycles.
- The earliest next accepted req is sampled on the edge that leaves DONE + 1, i.e. the first edge seen in IDLE.
- Back-to-back lookup throughput is at best one per k+3 cycles.

## Test plan
- Reset, then req with req_pa=0x0000100 → done after DEPTH+1 cycles, found=0, va=0, hit_idx=0.
- Install idx 5 with va=0x0123456, pa=0x0ABCDEF; req with pa 0x0ABCDEF → done 7 cycles after req, found=1, va=0x0123456, hit_idx=5.
- Install pa=0x0000040 at idx 3 (va 0x0000AAA) and at idx 7 (va 0x0000BBB); req → hit_idx=3, va=0x0000AAA.
- Invalidate idx 5 via wr_valid=0; req with pa 0x0ABCDEF → found=0. Previous va/hit_idx are held and done pulses for exactly one cycle.
- Start a scan for pa 0x1234567 with no match. While the scan is at idx 10, install that pa at idx 900 (va 0x0000321) and pulse req again → second req ignored; done at cycle 902, found=1, hit_idx=900.
- Drop rst_n while the scan is at idx 50 → busy=0 and done=0 immediately; after release, a req for a previously installed pa → found=0.
